cp0_regs: RTL

- Coprocessor-0 register file; the consumer of the exception code and CP0 write-enable produced by the M-stage exception/interrupt classifier.
- Holds SR, Cause, EPC and PRId. Captures the exception context on exception entry, clears it on eret, and serves mtc0/mfc0.
- Feeds SR back to the classifier, which uses it for the interrupt mask, EXL and IE gating.
- Feeds EPC to the fetch-stage PC mux.

---
 rtl/cp0_regs_pkg.sv | 37 +++
 rtl/cp0_regs_if.sv | 38 +++
 rtl/cp0_regs_timer.sv | 38 +++
 rtl/cp0_regs.sv | 110 +++++++++++
 4 files changed

// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, exception codes.
// Used by the CP0 register file and by the M-stage exception classifier.
package cp0_defs;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IM_HI     = 15;
    localparam int SR_IM_LO     = 10;
    localparam int SR_EXL       = 1;
    localparam int SR_IE        = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Restart address: a delay-slot instruction restarts at its branch (modulo 2^32).
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] base;
        base = pc & 32'hFFFF_FFFC;
        return bd ? base - 32'd4 : base;
    endfunction

endpackage

// File: rtl/cp0_regs_if.sv
// CP0 access bus: mfc0/mtc0, exception entry/eret and the SR/EPC/vector feedback.
// Carries timer_int only when CP0_TIMER_EN is defined.
interface cp0_regs_if;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic        exc_req;
    logic [5:0]  hwint;
    logic        eret;
    logic [31:0] rd_data;
    logic [31:0] sr;
    logic [31:0] epc;
    logic [31:0] vec_pc;
    logic        exl;
`ifdef CP0_TIMER_EN
    logic        timer_int;
`endif

    modport master (
        output rd_addr, wr_addr, wr_data, wr_en, pc, bd, exc_code, exc_req, hwint, eret,
        input  rd_data, sr, epc, vec_pc, exl
`ifdef CP0_TIMER_EN
        , input timer_int
`endif
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en, pc, bd, exc_code, exc_req, hwint, eret,
        output rd_data, sr, epc, vec_pc, exl
`ifdef CP0_TIMER_EN
        , output timer_int
`endif
    );
endinterface

// File: rtl/cp0_regs_timer.sv
// Count/Compare timer with sticky pending flag; only built when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);
    logic wr_count;
    logic wr_compare;

    assign wr_count   = wr_en && (wr_addr == REG_COUNT);
    assign wr_compare = wr_en && (wr_addr == REG_COMPARE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            pending <= 1'b0;
        end else begin
            count <= wr_count ? wr_data : count + 32'd1;
            if (wr_compare)
                compare <= wr_data;
            // Acknowledging via Compare wins over a coincident match.
            if (wr_compare)
                pending <= 1'b0;
            else if ((count == compare) && (compare != 32'd0))
                pending <= 1'b1;
        end
    end
endmodule
`endif

// File: rtl/cp0_regs.sv
// CP0 register file (SR, Cause, EPC, PRId): exception capture, eret, mtc0/mfc0.
// Define CP0_TIMER_EN to add Count/Compare and the timer_int output.
module cp0_regs
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID       = 32'h0000_4C58,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input logic       clk,
    input logic       reset,
    cp0_regs_if.slave bus
);
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic        mtc0_ok;
    logic        ip5;

    // A squashed (excepting) instruction must not commit its mtc0.
    assign mtc0_ok = bus.wr_en && !bus.exc_req;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pending;

    cp0_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mtc0_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .count   (count),
        .compare (compare),
        .pending (timer_pending)
    );

    assign ip5           = bus.hwint[5] | timer_pending;
    assign bus.timer_int = timer_pending;
`else
    assign ip5 = bus.hwint[5];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= {ip5, bus.hwint[4:0]};
            if (bus.exc_req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.bd;
                cause_exc <= bus.exc_code;
                epc_q     <= epc_of(bus.pc, bus.bd);
            end else begin
                if (mtc0_ok && (bus.wr_addr == REG_SR)) begin
                    sr_im  <= bus.wr_data[SR_IM_HI:SR_IM_LO];
                    sr_ie  <= bus.wr_data[SR_IE];
                    sr_exl <= bus.wr_data[SR_EXL] & ~bus.eret;
                end else if (bus.eret) begin
                    sr_exl <= 1'b0;
                end
                if (mtc0_ok && (bus.wr_addr == REG_EPC))
                    epc_q <= {bus.wr_data[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        sr_word                            = '0;
        sr_word[SR_IM_HI:SR_IM_LO]         = sr_im;
        sr_word[SR_EXL]                    = sr_exl;
        sr_word[SR_IE]                     = sr_ie;
        cause_word                         = '0;
        cause_word[CAUSE_BD]               = cause_bd;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO] = cause_ip;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            REG_SR:      bus.rd_data = sr_word;
            REG_CAUSE:   bus.rd_data = cause_word;
            REG_EPC:     bus.rd_data = epc_q;
            REG_PRID:    bus.rd_data = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   bus.rd_data = count;
            REG_COMPARE: bus.rd_data = compare;
`endif
            default:     bus.rd_data = '0;
        endcase
    end

    assign bus.sr     = sr_word;
    assign bus.epc    = epc_q;
    assign bus.vec_pc = EXC_VECTOR;
    assign bus.exl    = sr_exl;
endmodule
